// File: rtl/pe_vector_pkg.sv
// Shared types and width helpers for the channel-parallel MAC vector.
// PE_VECTOR_SAT_EN selects saturating (defined) or wrapping (undefined) oact narrowing.
package pe_vector_pkg;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  function automatic int prod_bitwidth(input int d);
    return 2 * d;
  endfunction

  function automatic int tree_levels(input int c);
    return $clog2(c);
  endfunction

  // Node width after lvl adder levels: one extra bit per level, never truncated.
  function automatic int tree_w(input int in_w, input int lvl);
    return in_w + lvl;
  endfunction

  // Bit offset of level lvl inside the flattened node bus of the adder tree.
  function automatic int tree_off(input int c, input int in_w, input int lvl);
    int off;
    off = 0;
    for (int j = 0; j < lvl; j++) begin
      off += (c >> j) * tree_w(in_w, j);
    end
    return off;
  endfunction

  // Narrows a shifted accumulator value to d bits; caller keeps the low d bits.
  function automatic logic [63:0] narrow_oact(input logic signed [63:0] v, input int unsigned d);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (d - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (d - 1));
`ifdef PE_VECTOR_SAT_EN
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
`else
    return v & (hi - lo);
`endif
  endfunction

endpackage

// File: rtl/pe_vector_acc_adder_tree_pipe.sv
// Pipelined binary adder tree: one register per level, sign-extending by one bit per level,
// with a matching valid/sideband shift pipe. Everything freezes while en is low.
module adder_tree_pipe
  import pe_vector_pkg::*;
#(
  parameter int C     = 32,
  parameter int IN_W  = 16,
  parameter int SB_W  = 7,
  localparam int L     = tree_levels(C),
  localparam int OUT_W = tree_w(IN_W, L)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [C*IN_W-1:0]   in_data,
  input  logic [SB_W-1:0]     in_sb,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  output logic [SB_W-1:0]     out_sb
);

  localparam int TOT_W = tree_off(C, IN_W, L + 1);

  // Level 0 is the raw input; level l sits at tree_off(l) with C>>l nodes.
  logic [TOT_W-1:0] node_bus;

  assign node_bus[C*IN_W-1:0] = in_data;

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int NW   = tree_w(IN_W, l);
    localparam int PW   = NW - 1;
    localparam int NN   = C >> l;
    localparam int OFF  = tree_off(C, IN_W, l);
    localparam int POFF = tree_off(C, IN_W, l - 1);

    logic [NN*NW-1:0] sum_d;
    logic [NN*NW-1:0] sum_q;

    always_comb begin
      sum_d = sum_q;
      if (en) begin
        for (int n = 0; n < NN; n++) begin
          sum_d[n*NW +: NW] = NW'($signed(node_bus[POFF + (2*n)*PW +: PW]))
                            + NW'($signed(node_bus[POFF + (2*n+1)*PW +: PW]));
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
      end else begin
        sum_q <= sum_d;
      end
    end

    assign node_bus[OFF +: NN*NW] = sum_q;
  end

  assign out_data = node_bus[tree_off(C, IN_W, L) +: OUT_W];

  logic [L-1:0]           vld_d;
  logic [L-1:0]           vld_q;
  logic [L-1:0][SB_W-1:0] sb_d;
  logic [L-1:0][SB_W-1:0] sb_q;

  always_comb begin
    vld_d = vld_q;
    sb_d  = sb_q;
    if (en) begin
      vld_d[0] = in_valid;
      sb_d[0]  = in_sb;
      for (int i = 1; i < L; i++) begin
        vld_d[i] = vld_q[i-1];
        sb_d[i]  = sb_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sb_q  <= '0;
    end else begin
      vld_q <= vld_d;
      sb_q  <= sb_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_sb    = sb_q[L-1];

endmodule

// File: rtl/pe_vector_acc.sv
// Channel-parallel MAC vector with cross-beat psum accumulation and requantisation.
// PE_VECTOR_SAT_EN: defined -> oact saturates after the shift; undefined -> oact wraps.
module pe_vector_acc
  import pe_vector_pkg::*;
#(
  parameter int DATA_BITWIDTH         = 8,
  parameter int NUM_OF_CHANNEL        = 32,
  parameter int WEIGHTS_ADDR_BITWIDTH = 4,
  parameter int ACC_BITWIDTH          = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wght_we,
  input  logic [WEIGHTS_ADDR_BITWIDTH-1:0]         wght_wr_addr,
  input  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  wght_din,
  input  logic [WEIGHTS_ADDR_BITWIDTH-1:0]         wght_rd_addr,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  iact,
  input  logic                                     in_first,
  input  logic                                     in_last,
  input  logic [4:0]                               shift,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_BITWIDTH-1:0]                 oact,
  output logic [ACC_BITWIDTH-1:0]                  out_psum,
  output logic                                     seq_err
);

  localparam int D             = DATA_BITWIDTH;
  localparam int C             = NUM_OF_CHANNEL;
  localparam int DEPTH         = 1 << WEIGHTS_ADDR_BITWIDTH;
  localparam int PROD_BITWIDTH = prod_bitwidth(D);
  localparam int TREE_LEVELS   = tree_levels(C);
  localparam int SUM_W         = tree_w(PROD_BITWIDTH, TREE_LEVELS);
  localparam int SB_W          = 7;

  // Handshake: a beat moves on in_valid && in_ready; the output is held while
  // out_valid && !out_ready, and in that case every stage freezes (adv low).
  logic adv;
  logic in_fire;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign in_fire  = in_valid && in_ready;

  // Weight regfile: reads are combinational, so a same-cycle write is seen next cycle.
  logic [D-1:0] wmem_q [C][DEPTH];

  always_ff @(posedge clk) begin
    if (wght_we) begin
      for (int g = 0; g < C; g++) begin
        wmem_q[g][wght_wr_addr] <= wght_din[g*D +: D];
      end
    end
  end

  logic                     m_valid_d, m_valid_q;
  logic [C*PROD_BITWIDTH-1:0] m_prod_d, m_prod_q;
  logic [SB_W-1:0]          m_sb_d, m_sb_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_prod_d  = m_prod_q;
    m_sb_d    = m_sb_q;
    if (adv) begin
      m_valid_d = in_fire;
      if (in_fire) begin
        m_sb_d = {in_first, in_last, shift};
        for (int g = 0; g < C; g++) begin
          m_prod_d[g*PROD_BITWIDTH +: PROD_BITWIDTH] =
            PROD_BITWIDTH'($signed(iact[g*D +: D])) * PROD_BITWIDTH'($signed(wmem_q[g][wght_rd_addr]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_prod_q  <= '0;
      m_sb_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_prod_q  <= m_prod_d;
      m_sb_q    <= m_sb_d;
    end
  end

  logic             t_valid;
  logic [SUM_W-1:0] t_sum;
  logic [SB_W-1:0]  t_sb;

  adder_tree_pipe #(
    .C    (C),
    .IN_W (PROD_BITWIDTH),
    .SB_W (SB_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (m_valid_q),
    .in_data   (m_prod_q),
    .in_sb     (m_sb_q),
    .out_valid (t_valid),
    .out_data  (t_sum),
    .out_sb    (t_sb)
  );

  logic                    t_first, t_last;
  logic [4:0]              t_shift;
  logic [ACC_BITWIDTH-1:0] sum_ext;
  logic                    acc_take;

  assign t_first  = t_sb[6];
  assign t_last   = t_sb[5];
  assign t_shift  = t_sb[4:0];
  assign sum_ext  = ACC_BITWIDTH'($signed(t_sum));
  assign acc_take = adv && t_valid;

  acc_state_e              state_d, state_q;
  logic [ACC_BITWIDTH-1:0] acc_d, acc_q;
  logic [ACC_BITWIDTH-1:0] acc_sum;
  logic                    restart;
  logic                    a_valid_d, a_valid_q;
  logic [ACC_BITWIDTH-1:0] a_res_d, a_res_q;
  logic [4:0]              a_shift_d, a_shift_q;
  logic                    seq_err_d, seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc_take) begin
      state_d = t_last ? ACC_IDLE : ACC_RUN;
    end
  end

  // A beat without first while idle starts a fresh sum and flags the error.
  always_comb begin
    restart   = t_first || (state_q == ACC_IDLE);
    acc_sum   = restart ? sum_ext : acc_q + sum_ext;
    acc_d     = acc_q;
    a_valid_d = adv ? 1'b0 : a_valid_q;
    a_res_d   = a_res_q;
    a_shift_d = a_shift_q;
    seq_err_d = 1'b0;
    if (acc_take) begin
      acc_d     = acc_sum;
      seq_err_d = !t_first && (state_q == ACC_IDLE);
      if (t_last) begin
        a_valid_d = 1'b1;
        a_res_d   = acc_sum;
        a_shift_d = t_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      a_valid_q <= 1'b0;
      a_res_q   <= '0;
      a_shift_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_valid_q <= a_valid_d;
      a_res_q   <= a_res_d;
      a_shift_q <= a_shift_d;
      seq_err_q <= seq_err_d;
    end
  end

  logic signed [ACC_BITWIDTH-1:0] shifted;
  logic                           out_valid_d, out_valid_q;
  logic [ACC_BITWIDTH-1:0]        out_psum_d, out_psum_q;
  logic [D-1:0]                   oact_d, oact_q;

  assign shifted = $signed(a_res_q) >>> a_shift_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_psum_d  = out_psum_q;
    oact_d      = oact_q;
    if (adv) begin
      out_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_psum_d = a_res_q;
        oact_d     = D'(narrow_oact(64'(shifted), D));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      oact_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_psum_q  <= out_psum_d;
      oact_q      <= oact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;
  assign oact      = oact_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_pe_vector_acc.sv
// Directed, table-driven bench for pe_vector_acc at C=32, D=8, ACC=32.
// Expected oact values follow PE_VECTOR_SAT_EN when it is defined for the build.
module tb_pe_vector_acc;

  localparam int D   = 8;
  localparam int C   = 32;
  localparam int W   = 4;
  localparam int ACC = 32;

`ifdef PE_VECTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           wght_we;
  logic [W-1:0]   wght_wr_addr;
  logic [C*D-1:0] wght_din;
  logic [W-1:0]   wght_rd_addr;
  logic           in_valid;
  logic           in_ready;
  logic [C*D-1:0] iact;
  logic           in_first;
  logic           in_last;
  logic [4:0]     shift;
  logic           out_valid;
  logic           out_ready;
  logic [D-1:0]   oact;
  logic [ACC-1:0] out_psum;
  logic           seq_err;

  always #5 clk = ~clk;

  pe_vector_acc #(
    .DATA_BITWIDTH         (D),
    .NUM_OF_CHANNEL        (C),
    .WEIGHTS_ADDR_BITWIDTH (W),
    .ACC_BITWIDTH          (ACC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wght_we      (wght_we),
    .wght_wr_addr (wght_wr_addr),
    .wght_din     (wght_din),
    .wght_rd_addr (wght_rd_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .iact         (iact),
    .in_first     (in_first),
    .in_last      (in_last),
    .shift        (shift),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .oact         (oact),
    .out_psum     (out_psum),
    .seq_err      (seq_err)
  );

  int checks = 0;
  int passes = 0;
  int out_cnt = 0;
  int seq_err_cnt = 0;

  // Scoreboard entries: {psum, oact}
  logic [ACC+D-1:0] exp_q[$];
  logic [ACC+D-1:0] exp_e;

  typedef struct {
    logic [D-1:0]   iact;
    logic [D-1:0]   w;
    logic [4:0]     sh;
    logic [ACC-1:0] psum;
    logic [D-1:0]   oact;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && seq_err) seq_err_cnt++;
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got psum 0x%0h, expected no output", out_psum);
      end else begin
        exp_e = exp_q.pop_front();
        check("out_psum", 64'(out_psum), 64'(exp_e[ACC+D-1:D]));
        check("oact", 64'(oact), 64'(exp_e[D-1:0]));
      end
    end
  end

  task automatic write_w(input logic [W-1:0] addr, input logic [D-1:0] w);
    @(negedge clk);
    wght_we      = 1'b1;
    wght_wr_addr = addr;
    wght_din     = {C{w}};
    @(posedge clk);
    #1;
    wght_we = 1'b0;
  endtask

  task automatic send_beat(input logic [C*D-1:0] av, input logic [W-1:0] ra,
                           input logic f, input logic l, input logic [4:0] sh);
    int n;
    @(negedge clk);
    iact         = av;
    wght_rd_addr = ra;
    in_first     = f;
    in_last      = l;
    shift        = sh;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_oact", 64'(oact), 64'd0);
    check("rst_out_psum", 64'(out_psum), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int out0;
    int seq0;
    logic [C*D-1:0] av;

    vecs[0] = '{8'd1,  8'd1,  5'd0,  32'd32,         8'h20};
    vecs[1] = '{8'd3,  8'hFE, 5'd0,  32'hFFFFFF40,   SAT ? 8'h80 : 8'h40};
    vecs[2] = '{8'h80, 8'h80, 5'd8,  32'h00080000,   SAT ? 8'h7F : 8'h00};
    vecs[3] = '{8'h7F, 8'h80, 5'd10, 32'hFFF81000,   SAT ? 8'h80 : 8'h04};
    vecs[4] = '{8'd5,  8'd7,  5'd2,  32'd1120,       SAT ? 8'h7F : 8'h18};
    vecs[5] = '{8'hFF, 8'd1,  5'd3,  32'hFFFFFFE0,   8'hFC};
    vecs[6] = '{8'd2,  8'd1,  5'd31, 32'd64,         8'h00};
    vecs[7] = '{8'hFD, 8'd5,  5'd4,  32'hFFFFFE20,   8'hE2};

    rst = 1'b1; wght_we = 1'b0; wght_wr_addr = '0; wght_din = '0; wght_rd_addr = '0;
    in_valid = 1'b0; iact = '0; in_first = 1'b0; in_last = 1'b0; shift = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) write_w(W'(i), vecs[i].w);
    write_w(4'd9, 8'hFE);
    write_w(4'd12, 8'd2);

    // Single-beat latency: out_valid must appear 7 edges after the accepting edge.
    exp_q.push_back({vecs[0].psum, vecs[0].oact});
    send_beat({C{vecs[0].iact}}, 4'd0, 1'b1, 1'b1, vecs[0].sh);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 50);
    check("latency", 64'(n), 64'd7);
    wait_drain("drain_latency");

    // Back-to-back single-beat table.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].psum, vecs[i].oact});
      send_beat({C{vecs[i].iact}}, W'(i), 1'b1, 1'b1, vecs[i].sh);
    end
    wait_drain("drain_table");

    // Lane-varying iact (g-16) with w=1: sum is -16.
    for (int g = 0; g < C; g++) av[g*D +: D] = 8'(g - 16);
    exp_q.push_back({32'hFFFFFFF0, 8'hF0});
    send_beat(av, 4'd0, 1'b1, 1'b1, 5'd0);
    wait_drain("drain_lanes");

    // Four-beat accumulation: 4 * 32 * (3 * -2) = -768.
    exp_q.push_back({32'hFFFFFD00, SAT ? 8'h80 : 8'h00});
    send_beat({C{8'd3}}, 4'd9, 1'b1, 1'b0, 5'd0);
    send_beat({C{8'd3}}, 4'd9, 1'b0, 1'b0, 5'd0);
    send_beat({C{8'd3}}, 4'd9, 1'b0, 1'b0, 5'd0);
    send_beat({C{8'd3}}, 4'd9, 1'b0, 1'b1, 5'd0);
    wait_drain("drain_multi");

    // Output stall: result held, input blocked, second result not lost.
    out0 = out_cnt;
    out_ready = 1'b0;
    exp_q.push_back({vecs[4].psum, vecs[4].oact});
    exp_q.push_back({vecs[0].psum, vecs[0].oact});
    send_beat({C{vecs[4].iact}}, 4'd4, 1'b1, 1'b1, vecs[4].sh);
    send_beat({C{vecs[0].iact}}, 4'd0, 1'b1, 1'b1, vecs[0].sh);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_psum", 64'(out_psum), 64'(vecs[4].psum));
      check("stall_oact", 64'(oact), 64'(vecs[4].oact));
    end
    out_ready = 1'b1;
    wait_drain("drain_stall");
    check("stall_out_count", 64'(out_cnt - out0), 64'd2);

    // Non-first beat after reset: seq_err pulse, result is that beat's own sum.
    do_reset();
    seq0 = seq_err_cnt;
    exp_q.push_back({32'd32, 8'h20});
    send_beat({C{8'd1}}, 4'd0, 1'b0, 1'b1, 5'd0);
    wait_drain("drain_seq_err");
    check("seq_err_pulse", 64'(seq_err_cnt - seq0), 64'd1);

    // Same-cycle write/read of a weight: old value (2) used, new value (5) next beat.
    @(negedge clk);
    wght_we = 1'b1; wght_wr_addr = 4'd12; wght_din = {C{8'd5}};
    iact = {C{8'd1}}; wght_rd_addr = 4'd12; in_first = 1'b1; in_last = 1'b1; shift = 5'd0;
    in_valid = 1'b1;
    check("wr_rd_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({32'd64, 8'h40});
    @(posedge clk);
    #1;
    wght_we = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back({32'd160, SAT ? 8'h7F : 8'hA0});
    send_beat({C{8'd1}}, 4'd12, 1'b1, 1'b1, 5'd0);
    wait_drain("drain_wr_rd");

    // Reset after two of four beats: nothing emerges, fresh pair is clean.
    out0 = out_cnt;
    seq0 = seq_err_cnt;
    send_beat({C{8'd7}}, 4'd0, 1'b1, 1'b0, 5'd0);
    send_beat({C{8'd7}}, 4'd0, 1'b0, 1'b0, 5'd0);
    do_reset();
    repeat (15) @(negedge clk);
    check("rst_no_output", 64'(out_cnt - out0), 64'd0);
    exp_q.push_back({32'd64, 8'h40});
    send_beat({C{8'd1}}, 4'd0, 1'b1, 1'b0, 5'd0);
    send_beat({C{8'd1}}, 4'd0, 1'b0, 1'b1, 5'd0);
    wait_drain("drain_after_rst");
    check("rst_no_seq_err", 64'(seq_err_cnt - seq0), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
